vic_int_ctrl: RTL and testbench
===============================

VIC_INT_CTRL -- requirements
Module: vic_int_ctrl

Interface
REQ-001 SHALL have port vic_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port vic_rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port pad_vic_int_vld, input, 32 bits: interrupt lines from the wakeup block, one per source.
REQ-004 SHALL have port pad_vic_int_cfg, input, 32 bits: per line, 0 = level-sensitive, 1 = rising-edge (latched).
REQ-005 SHALL have port vic_int_enable, input, 32 bits: per-line enable mask.
REQ-006 SHALL have port vic_cpu_int_req, output, 1 bit: interrupt request to the CPU.
REQ-007 SHALL have port vic_cpu_int_vec, output, 5 bits: vector index of the request; valid only while the request is high.
REQ-008 SHALL have port cpu_vic_int_ack, input, 1 bit: CPU accepts the current request.
REQ-009 SHALL have port cpu_vic_int_done, input, 1 bit: CPU handler exit.
REQ-010 SHALL have port vic_int_clr, output, 32 bits: one-hot pulse marking the accepted vector.
REQ-011 SHALL have port vic_busy, output, 1 bit: high while a handler is in service.

Function
REQ-012 SHALL keep a 32-bit edge-pending register; bit i sets when cfg[i]=1 and vld[i] rises (compared with the previous-cycle sampled value).
REQ-013 SHALL form the candidate vector per line: level lines (cfg=0) use vld[i]; edge lines use the pending bit. Candidate = that value AND enable[i].
REQ-014 SHALL arbitrate by fixed priority; the lowest index wins.
REQ-015 SHALL implement FSM states IDLE, REQ and SERVE.
REQ-016 IDLE: if any candidate is set in cycle N, then in cycle N+1 req=1, vec=winner index, state=REQ.
REQ-017 REQ: re-arbitrate every cycle; vec tracks the current winner, so a higher-priority arrival preempts before ack.
REQ-018 REQ with no candidate (level line withdrawn, or mask cleared): next cycle req=0, state=IDLE.
REQ-019 Ack in REQ at cycle M: next cycle req=0, state=SERVE, busy=1, vic_int_clr = one-hot of the vec shown at M, for exactly one cycle.
REQ-020 Ack and withdrawal in the same cycle: ack wins; the vec shown that cycle is accepted.
REQ-021 Accepting an edge line clears its pending bit. If a new edge on the same line arrives in the same cycle, set wins.
REQ-022 SERVE: no request is raised; edges keep latching. cpu_vic_int_done at cycle D gives IDLE and busy=0 at D+1; the earliest new req is at D+2.
REQ-023 SHALL ignore ack outside REQ and done outside SERVE.
REQ-024 SHALL drive vec to 0 whenever req=0.

Reset
REQ-025 While vic_rst is high at a clock edge: state=IDLE, pending=0, the previous-vld sample=0, and req, vec, vic_int_clr and busy all 0.
REQ-026 Reset asserted mid-REQ or mid-SERVE SHALL abandon the transaction with no clr pulse.
REQ-027 The first cycle after reset SHALL NOT detect an edge on a line that was already high; that cycle only captures the sample.

Structure
REQ-028 Shared package vic_pkg SHALL hold NUM_INT=32, VEC_W=5 and the FSM state enum.
REQ-029 The fixed-priority 32-to-5 encoder (with an any-valid output) SHALL be the sub-module vic_prio_enc.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Level vld[5]=1, enable[5]=1 at cycle 0 -> req=1, vec=5 at cycle 1; ack at cycle 3 -> clr=0x20 at cycle 4, busy=1; done at cycle 6 -> busy=0 at cycle 7.
REQ-032 vld[9] active, in REQ, then vld[2] rises before ack -> vec changes from 9 to 2 the next cycle; ack -> clr=0x4.
REQ-033 Edge line 3: one-cycle pulse, disabled line 3 at first, enable raised later -> req with vec=3 from the latched pending bit; after ack the pending bit is 0; a second edge during the ack cycle keeps it 1.
REQ-034 Level vld[7] drops in REQ with no ack -> req=0 next cycle, no clr pulse, state IDLE.
REQ-035 Reset pulsed while in SERVE -> all outputs 0 next cycle; a stray done is ignored; a line already high at reset release is not treated as an edge.

Source files
------------

// File: rtl/vic_pkg.sv
// vic_pkg: shared constants, FSM state encoding and helpers for the
// vectored interrupt controller.
//   NUM_INT     - number of interrupt lines
//   VEC_W       - width of a vector index
//   vic_state_e - controller FSM states
//   vec_onehot  - vector index to one-hot line mask
package vic_pkg;

  localparam int NUM_INT = 32;
  localparam int VEC_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2
  } vic_state_e;

  function automatic logic [NUM_INT-1:0] vec_onehot(input logic [VEC_W-1:0] v);
    return {{(NUM_INT-1){1'b0}}, 1'b1} << v;
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// vic_prio_enc: fixed-priority encoder, lowest set index wins.
// Purely combinational.
//   req_i [NUM_INT-1:0] - candidate lines
//   any_o               - at least one candidate set
//   idx_o [VEC_W-1:0]   - index of the winning line (0 when none)
module vic_prio_enc
  import vic_pkg::*;
(
  input  logic [NUM_INT-1:0] req_i,
  output logic               any_o,
  output logic [VEC_W-1:0]   idx_o
);

  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    // Scan downward so the last assignment is the lowest set index.
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/vic_int_ctrl.sv
// vic_int_ctrl: vectored interrupt controller. Merges level and latched
// rising-edge interrupt lines, arbitrates by fixed priority and runs a
// request / acknowledge / service handshake with the CPU.
//   vic_clk, vic_rst   - clock, synchronous active-high reset
//   pad_vic_int_vld    - interrupt lines, one per source
//   pad_vic_int_cfg    - per line: 0 level, 1 rising edge
//   vic_int_enable     - per line enable mask
//   vic_cpu_int_req    - request to the CPU (registered)
//   vic_cpu_int_vec    - vector of the request, 0 while no request
//   cpu_vic_int_ack    - CPU accepts the shown vector
//   cpu_vic_int_done   - CPU handler exit
//   vic_int_clr        - one-cycle one-hot pulse of the accepted vector
//   vic_busy           - a handler is in service
//
// State    | meaning
// ST_IDLE  | no request outstanding, waiting for a candidate
// ST_REQ   | request shown to CPU, vector re-arbitrated each cycle
// ST_SERVE | vector accepted, handler running until done
module vic_int_ctrl
  import vic_pkg::*;
(
  input  logic               vic_clk,
  input  logic               vic_rst,
  input  logic [NUM_INT-1:0] pad_vic_int_vld,
  input  logic [NUM_INT-1:0] pad_vic_int_cfg,
  input  logic [NUM_INT-1:0] vic_int_enable,
  output logic               vic_cpu_int_req,
  output logic [VEC_W-1:0]   vic_cpu_int_vec,
  input  logic               cpu_vic_int_ack,
  input  logic               cpu_vic_int_done,
  output logic [NUM_INT-1:0] vic_int_clr,
  output logic               vic_busy
);

  vic_state_e         state_q, state_d;
  logic [NUM_INT-1:0] pend_q, pend_d;
  logic [NUM_INT-1:0] vld_prev_q;
  // Low for the first cycle after reset so a line already high is only
  // sampled, not mistaken for a rising edge.
  logic               samp_vld_q;
  logic               req_q, req_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_INT-1:0] clr_q, clr_d;
  logic               busy_q, busy_d;

  logic [NUM_INT-1:0] edge_det;
  logic [NUM_INT-1:0] cand;
  logic [NUM_INT-1:0] accept_mask;
  logic               cand_any;
  logic [VEC_W-1:0]   cand_idx;

  assign edge_det = pad_vic_int_cfg & pad_vic_int_vld & ~vld_prev_q
                  & {NUM_INT{samp_vld_q}};

  assign cand = ((~pad_vic_int_cfg & pad_vic_int_vld) |
                 ( pad_vic_int_cfg & pend_q)) & vic_int_enable;

  vic_prio_enc u_prio_enc (
    .req_i (cand),
    .any_o (cand_any),
    .idx_o (cand_idx)
  );

  // A new edge in the accept cycle must survive the clear.
  assign pend_d = (pend_q & ~accept_mask) | edge_det;

  always_comb begin
    state_d     = state_q;
    req_d       = 1'b0;
    vec_d       = '0;
    clr_d       = '0;
    busy_d      = busy_q;
    accept_mask = '0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (cand_any) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          vec_d   = cand_idx;
        end
      end
      ST_REQ: begin
        // Ack takes the vector currently on the bus even if its line was
        // withdrawn in the same cycle.
        if (cpu_vic_int_ack) begin
          state_d     = ST_SERVE;
          busy_d      = 1'b1;
          clr_d       = vec_onehot(vec_q);
          accept_mask = vec_onehot(vec_q);
        end else if (cand_any) begin
          req_d = 1'b1;
          vec_d = cand_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        busy_d = 1'b1;
        if (cpu_vic_int_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge vic_clk) begin
    if (vic_rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      vld_prev_q <= '0;
      samp_vld_q <= 1'b0;
      req_q      <= 1'b0;
      vec_q      <= '0;
      clr_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      vld_prev_q <= pad_vic_int_vld;
      samp_vld_q <= 1'b1;
      req_q      <= req_d;
      vec_q      <= vec_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
    end
  end

  assign vic_cpu_int_req = req_q;
  assign vic_cpu_int_vec = vec_q;
  assign vic_int_clr     = clr_q;
  assign vic_busy        = busy_q;

endmodule

// File: tb/tb_vic_int_ctrl.sv
// tb_vic_int_ctrl: directed bench for vic_int_ctrl. Each step drives the
// inputs for one cycle, pushes the outputs expected after the next rising
// edge into a scoreboard queue, then pops and compares them.
module tb_vic_int_ctrl;

  logic        vic_clk = 1'b0;
  logic        vic_rst;
  logic [31:0] pad_vic_int_vld;
  logic [31:0] pad_vic_int_cfg;
  logic [31:0] vic_int_enable;
  logic        vic_cpu_int_req;
  logic [4:0]  vic_cpu_int_vec;
  logic        cpu_vic_int_ack;
  logic        cpu_vic_int_done;
  logic [31:0] vic_int_clr;
  logic        vic_busy;

  typedef struct {
    string       tag;
    logic        req;
    logic [4:0]  vec;
    logic [31:0] clr;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  vic_int_ctrl dut (
    .vic_clk          (vic_clk),
    .vic_rst          (vic_rst),
    .pad_vic_int_vld  (pad_vic_int_vld),
    .pad_vic_int_cfg  (pad_vic_int_cfg),
    .vic_int_enable   (vic_int_enable),
    .vic_cpu_int_req  (vic_cpu_int_req),
    .vic_cpu_int_vec  (vic_cpu_int_vec),
    .cpu_vic_int_ack  (cpu_vic_int_ack),
    .cpu_vic_int_done (cpu_vic_int_done),
    .vic_int_clr      (vic_int_clr),
    .vic_busy         (vic_busy)
  );

  always #5 vic_clk = ~vic_clk;

  task automatic step(input string tag, input logic req, input logic [4:0] vec,
                      input logic [31:0] clr, input logic busy);
    exp_t e;
    e.tag  = tag;
    e.req  = req;
    e.vec  = vec;
    e.clr  = clr;
    e.busy = busy;
    sb_q.push_back(e);
    @(posedge vic_clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (vic_cpu_int_req === e.req) else begin
      errors++;
      $error("FAIL %s req: observed %0b expected %0b", e.tag, vic_cpu_int_req, e.req);
    end
    checks++;
    assert (vic_cpu_int_vec === e.vec) else begin
      errors++;
      $error("FAIL %s vec: observed %0d expected %0d", e.tag, vic_cpu_int_vec, e.vec);
    end
    checks++;
    assert (vic_int_clr === e.clr) else begin
      errors++;
      $error("FAIL %s clr: observed %08h expected %08h", e.tag, vic_int_clr, e.clr);
    end
    checks++;
    assert (vic_busy === e.busy) else begin
      errors++;
      $error("FAIL %s busy: observed %0b expected %0b", e.tag, vic_busy, e.busy);
    end
  endtask

  initial begin
    vic_rst          = 1'b1;
    pad_vic_int_vld  = '0;
    pad_vic_int_cfg  = '0;
    vic_int_enable   = '0;
    cpu_vic_int_ack  = 1'b0;
    cpu_vic_int_done = 1'b0;
    #2;
    step("reset0", 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0);
    vic_rst = 1'b0;
    step("idle", 0, 0, 0, 0);

    // Basic level flow on line 5
    pad_vic_int_vld = 32'h20; vic_int_enable = 32'h20;
    step("lvl5_c1", 1, 5, 0, 0);
    step("lvl5_c2", 1, 5, 0, 0);
    cpu_vic_int_ack = 1'b1;
    step("lvl5_ack", 0, 0, 32'h20, 1);
    cpu_vic_int_ack = 1'b0; pad_vic_int_vld = '0;
    step("lvl5_serve", 0, 0, 0, 1);
    step("lvl5_serve2", 0, 0, 0, 1);
    cpu_vic_int_done = 1'b1;
    step("lvl5_done", 0, 0, 0, 0);
    cpu_vic_int_done = 1'b0;
    step("lvl5_idle", 0, 0, 0, 0);

    // Ack and done outside their states are ignored
    cpu_vic_int_ack = 1'b1;
    step("stray_ack", 0, 0, 0, 0);
    cpu_vic_int_ack = 1'b0; cpu_vic_int_done = 1'b1;
    step("stray_done", 0, 0, 0, 0);
    cpu_vic_int_done = 1'b0;

    // Preemption: 9 shown, then 2 arrives
    vic_int_enable = '1; pad_vic_int_vld = 32'h200;
    step("pre_9", 1, 9, 0, 0);
    pad_vic_int_vld = 32'h204;
    step("pre_2", 1, 2, 0, 0);
    cpu_vic_int_ack = 1'b1;
    step("pre_ack", 0, 0, 32'h4, 1);
    cpu_vic_int_ack = 1'b0; pad_vic_int_vld = '0;
    step("pre_serve", 0, 0, 0, 1);
    cpu_vic_int_done = 1'b1;
    step("pre_done", 0, 0, 0, 0);
    cpu_vic_int_done = 1'b0;
    step("pre_idle", 0, 0, 0, 0);

    // Edge line 3: pulse while disabled, enable later
    pad_vic_int_cfg = 32'h8; vic_int_enable = '0; pad_vic_int_vld = 32'h8;
    step("edge_pulse", 0, 0, 0, 0);
    pad_vic_int_vld = '0;
    step("edge_masked1", 0, 0, 0, 0);
    step("edge_masked2", 0, 0, 0, 0);
    vic_int_enable = 32'h8;
    step("edge_req", 1, 3, 0, 0);
    cpu_vic_int_ack = 1'b1;
    step("edge_ack", 0, 0, 32'h8, 1);
    cpu_vic_int_ack = 1'b0;
    step("edge_serve", 0, 0, 0, 1);
    cpu_vic_int_done = 1'b1;
    step("edge_done", 0, 0, 0, 0);
    cpu_vic_int_done = 1'b0;
    step("edge_cleared", 0, 0, 0, 0);
    step("edge_cleared2", 0, 0, 0, 0);

    // New edge in the ack cycle keeps the pending bit
    pad_vic_int_vld = 32'h8;
    step("edge2_pulse", 0, 0, 0, 0);
    pad_vic_int_vld = '0;
    step("edge2_req", 1, 3, 0, 0);
    cpu_vic_int_ack = 1'b1; pad_vic_int_vld = 32'h8;
    step("edge2_ack", 0, 0, 32'h8, 1);
    cpu_vic_int_ack = 1'b0; pad_vic_int_vld = '0;
    step("edge2_serve", 0, 0, 0, 1);
    cpu_vic_int_done = 1'b1;
    step("edge2_done", 0, 0, 0, 0);
    cpu_vic_int_done = 1'b0;
    step("edge2_rereq", 1, 3, 0, 0);
    cpu_vic_int_ack = 1'b1;
    step("edge2_ack2", 0, 0, 32'h8, 1);
    cpu_vic_int_ack = 1'b0;
    step("edge2_serve2", 0, 0, 0, 1);
    cpu_vic_int_done = 1'b1;
    step("edge2_done2", 0, 0, 0, 0);
    cpu_vic_int_done = 1'b0;
    step("edge2_idle", 0, 0, 0, 0);
    pad_vic_int_cfg = '0;

    // Level 7 withdrawn, then mask cleared
    vic_int_enable = '1; pad_vic_int_vld = 32'h80;
    step("wd_req", 1, 7, 0, 0);
    pad_vic_int_vld = '0;
    step("wd_drop", 0, 0, 0, 0);
    step("wd_idle", 0, 0, 0, 0);
    pad_vic_int_vld = 32'h80;
    step("mask_req", 1, 7, 0, 0);
    vic_int_enable = '0;
    step("mask_drop", 0, 0, 0, 0);
    pad_vic_int_vld = '0; vic_int_enable = '1;
    step("mask_idle", 0, 0, 0, 0);

    // Ack and withdrawal in the same cycle
    pad_vic_int_vld = 32'h10;
    step("ackwd_req", 1, 4, 0, 0);
    pad_vic_int_vld = '0; cpu_vic_int_ack = 1'b1;
    step("ackwd_ack", 0, 0, 32'h10, 1);
    cpu_vic_int_ack = 1'b0;
    step("ackwd_serve", 0, 0, 0, 1);
    cpu_vic_int_done = 1'b1;
    step("ackwd_done", 0, 0, 0, 0);
    cpu_vic_int_done = 1'b0;

    // Reset during SERVE, stray done, line high at reset release
    pad_vic_int_vld = 32'h40;
    step("rst_req", 1, 6, 0, 0);
    cpu_vic_int_ack = 1'b1;
    step("rst_ack", 0, 0, 32'h40, 1);
    cpu_vic_int_ack = 1'b0; pad_vic_int_vld = '0;
    step("rst_serve", 0, 0, 0, 1);
    pad_vic_int_cfg = 32'h2; pad_vic_int_vld = 32'h2; vic_rst = 1'b1;
    step("rst_mid_serve", 0, 0, 0, 0);
    vic_rst = 1'b0; cpu_vic_int_done = 1'b1;
    step("rst_first", 0, 0, 0, 0);
    cpu_vic_int_done = 1'b0;
    step("rst_no_edge1", 0, 0, 0, 0);
    step("rst_no_edge2", 0, 0, 0, 0);
    pad_vic_int_vld = '0;
    step("rst_low", 0, 0, 0, 0);
    pad_vic_int_vld = 32'h2;
    step("rst_edge", 0, 0, 0, 0);
    step("rst_edge_req", 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
